signed_multiplier: RTL and testbench

SIGNED_MULTIPLIER -- requirements
Module: signed_multiplier

---
 rtl/signed_mul_pkg.sv | 13 +
 rtl/signed_multiplier_booth_step.sv | 36 +++
 rtl/signed_multiplier.sv | 114 +++++++++++
 tb/tb_signed_multiplier.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/signed_mul_pkg.sv
// Shared definitions for the multiplier/divider blocks: default operand
// width and the common IDLE/CALC/DONE state enumeration.
package signed_mul_pkg;

  localparam int unsigned MUL_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/signed_multiplier_booth_step.sv
// booth_step: one radix-2 Booth iteration. Adds/subtracts the
// sign-extended multiplicand into the W+1 bit accumulator according to
// {q[0],q_1}, then arithmetic-shifts {a,q,q_1} right by one.
module booth_step
  import signed_mul_pkg::*;
#(
  parameter int unsigned W = MUL_W
) (
  input  logic [W:0]   a,
  input  logic [W-1:0] q,
  input  logic         q_1,
  input  logic [W-1:0] m,
  output logic [W:0]   a_nxt,
  output logic [W-1:0] q_nxt,
  output logic         q_1_nxt
);

  logic [W:0] m_ext;
  logic [W:0] sum;

  assign m_ext = {m[W-1], m};

  // Booth recode, then arithmetic shift of the combined register
  always_comb begin
    sum = a;
    case ({q[0], q_1})
      2'b01:   sum = a + m_ext;
      2'b10:   sum = a - m_ext;
      default: sum = a;
    endcase
    a_nxt   = {sum[W], sum[W:1]};
    q_nxt   = {sum[0], q[W-1:1]};
    q_1_nxt = q[0];
  end

endmodule

// File: rtl/signed_multiplier.sv
// signed_multiplier: sequential radix-2 Booth multiplier, W Booth steps
// per operation, done pulses W+1 cycles after the start edge.
// Optional overflow flag enabled by defining SIGNED_MUL_OVF_EN.
module signed_multiplier
  import signed_mul_pkg::*;
#(
  parameter int unsigned W = MUL_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           st,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic [2*W-1:0] prod,
  output logic           busy,
  output logic           done
`ifdef SIGNED_MUL_OVF_EN
  ,
  output logic           ovf
`endif
);

  localparam int unsigned CW = $clog2(W + 1);

  mul_state_e     state, state_nxt;
  logic [W:0]     a;
  logic [W-1:0]   m;
  logic [W-1:0]   q;
  logic           q_1;
  logic [CW-1:0]  cnt;
  logic [W:0]     a_step;
  logic [W-1:0]   q_step;
  logic           q_1_step;
  logic           start;
  logic           last;
  logic [2*W-1:0] prod_nxt;

  // Start is honoured only outside CALC; last is the cycle after the Wth step
  assign start    = st && (state != CALC);
  assign last     = (cnt == CW'(W));
  assign busy     = (state == CALC);
  assign prod_nxt = {a[W-1:0], q};

  booth_step #(.W(W)) u_step (
    .a       (a),
    .q       (q),
    .q_1     (q_1),
    .m       (m),
    .a_nxt   (a_step),
    .q_nxt   (q_step),
    .q_1_nxt (q_1_step)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (st) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = st ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, Booth iterations and result load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a    <= '0;
      m    <= '0;
      q    <= '0;
      q_1  <= 1'b0;
      cnt  <= '0;
      prod <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        m   <= mcand;
        q   <= mplier;
        a   <= '0;
        q_1 <= 1'b0;
        cnt <= '0;
      end else if (state == CALC) begin
        if (last) begin
          prod <= prod_nxt;
          done <= 1'b1;
        end else begin
          a   <= a_step;
          q   <= q_step;
          q_1 <= q_1_step;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

`ifdef SIGNED_MUL_OVF_EN
  logic [W:0] top_bits;
  assign top_bits = prod_nxt[2*W-1:W-1];

  // Overflow flag updated alongside prod
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        ovf <= 1'b0;
    else if (state == CALC && last) ovf <= !((&top_bits) || !(|top_bits));
  end
`endif

endmodule

// File: tb/tb_signed_multiplier.sv
// Self-checking bench for signed_multiplier (W=16): table of directed
// vectors plus hand-written sequences for the multi-cycle corner cases.
module tb_signed_multiplier;

  localparam int unsigned W = 16;
  localparam int LAT = 17;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           st = 1'b0;
  logic [W-1:0]   mcand = '0;
  logic [W-1:0]   mplier = '0;
  logic [2*W-1:0] prod;
  logic           busy;
  logic           done;
`ifdef SIGNED_MUL_OVF_EN
  logic           ovf;
`endif

  int errors = 0;
  int checks = 0;

  signed_multiplier #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .st     (st),
    .mcand  (mcand),
    .mplier (mplier),
    .prod   (prod),
    .busy   (busy),
    .done   (done)
`ifdef SIGNED_MUL_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    logic           o;
    string          nm;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Counts edges after the capture edge until done is seen (bounded)
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] ep, input logic eo, input string nm);
    int n;
    @(negedge clk);
    mcand = a; mplier = b; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    mcand = ~a; mplier = ~b;
    chk({nm, " busy"}, {31'b0, busy}, 32'd1);
    wait_done(n);
    chk({nm, " latency"}, 32'(n), 32'(LAT));
    chk({nm, " prod"}, prod, ep);
`ifdef SIGNED_MUL_OVF_EN
    chk({nm, " ovf"}, {31'b0, ovf}, {31'b0, eo});
`else
    if (eo === 1'bx) $display("unexpected x in expected ovf");
`endif
    @(posedge clk); #1;
    chk({nm, " done pulse"}, {31'b0, done}, 32'd0);
    chk({nm, " idle busy"}, {31'b0, busy}, 32'd0);
    chk({nm, " prod held"}, prod, ep);
  endtask

  initial begin
    int n, first, pulses;

    vecs[0] = '{16'd7,      16'hFFFD, 32'hFFFF_FFEB, 1'b0, "7x-3"};
    vecs[1] = '{16'h8000,   16'h8000, 32'h4000_0000, 1'b1, "min x min"};
    vecs[2] = '{16'hFFFF,   16'hFFFF, 32'h0000_0001, 1'b0, "-1x-1"};
    vecs[3] = '{16'd0,      16'h7FFF, 32'h0000_0000, 1'b0, "0xmax"};
    vecs[4] = '{16'd100,    16'd200,  32'h0000_4E20, 1'b0, "100x200"};
    vecs[5] = '{16'h7FFF,   16'h7FFF, 32'h3FFF_0001, 1'b1, "max x max"};
    vecs[6] = '{16'h8000,   16'd1,    32'hFFFF_8000, 1'b0, "min x 1"};
    vecs[7] = '{16'd123,    16'hFE38, 32'hFFFF_24E8, 1'b1, "123x-456"};

    // Reset state
    #2;
    chk("reset prod", prod, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
`ifdef SIGNED_MUL_OVF_EN
    chk("reset ovf", {31'b0, ovf}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].o, vecs[i].nm);

    // Second start and operand change mid-operation are ignored
    @(negedge clk);
    mcand = 16'd7; mplier = 16'hFFFD; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    first = 0; pulses = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin st = 1'b1; mcand = 16'd100; mplier = 16'd200; end
      if (k == 6) st = 1'b0;
      if (done) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    chk("ignore st latency", 32'(first), 32'(LAT));
    chk("ignore st pulses", 32'(pulses), 32'd1);
    chk("ignore st prod", prod, 32'hFFFF_FFEB);

    // Reset in the middle of CALC discards the operation
    @(negedge clk);
    mcand = 16'd100; mplier = 16'd200; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    st = 1'b1;
    #1;
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset prod", prod, 32'd0);
    chk("midreset done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    chk("st during rst busy", {31'b0, busy}, 32'd0);
    rst = 1'b0; st = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("after reset quiet", 32'(pulses), 32'd0);
    run_op(16'hFFFB, 16'd9, 32'hFFFF_FFD3, 1'b0, "post reset -5x9");

    // Start held in DONE cycle launches the next operation back to back
    @(negedge clk);
    mcand = 16'd7; mplier = 16'hFFFD; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    wait_done(n);
    chk("b2b first prod", prod, 32'hFFFF_FFEB);
    st = 1'b1; mcand = 16'd100; mplier = 16'd200;
    @(posedge clk); #1;
    st = 1'b0;
    chk("b2b restart busy", {31'b0, busy}, 32'd1);
    chk("b2b done dropped", {31'b0, done}, 32'd0);
    chk("b2b prod held", prod, 32'hFFFF_FFEB);
    wait_done(n);
    chk("b2b latency", 32'(n), 32'(LAT));
    chk("b2b prod", prod, 32'h0000_4E20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
